seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Multi-digit, time-multiplexed 7-segment display driver; parametrised successor of the single-digit BCD decoder.
//   Captures NUM_DIGITS packed BCD digits and scans them one at a time onto a shared segment bus with one-hot digit enables.
//   Renders a per-digit error glyph and inserts an anti-ghosting blank slot at every digit switch.
//   Sits between the arithmetic/control core and the board display pins.
// PARAMETERS
//   NUM_DIGITS     4      digits driven; >=1
//   SCAN_DIV       50000  clk cycles per digit slot, including the 1-cycle blank; >=2
//   ACTIVE_LOW_SEG 1      1: segment lit = 0 (board default); 0: lit = 1
//   ACTIVE_LOW_AN  1      1: digit enabled = 0; 0: enabled = 1
// PORTS
//   clk      in   1             system clock, rising edge
//   rst_n    in   1             asynchronous, active-low reset
//   bcd_in   in   4*NUM_DIGITS  packed digits; [3:0] = digit 0 (rightmost, least significant)
//   load     in   1             1-cycle strobe: capture bcd_in into the hold register
//   err      in   1             level: while 1, every digit shows the error glyph 'E'
//   seg_out  out  7             segments; bit0=a .. bit6=g; polarity set by ACTIVE_LOW_SEG
//   an_out   out  NUM_DIGITS    digit enables, at most one active; polarity set by ACTIVE_LOW_AN
// BEHAVIOUR
//   - Reset (async assert, sync release): hold reg=0, prescaler=0, idx=0, seg_out=all segments off, an_out=all digits off.
//   - Hold reg: at the clk edge with load=1, takes bcd_in. Otherwise holds. Display updates when each digit is next scanned.
//   - Prescaler: counts 0..SCAN_DIV-1 and wraps to 0.
//   - On the edge where prescaler==SCAN_DIV-1:
//       idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1
//       an_out <= all off; seg_out <= blank   (guard cycle)
//   - On every other edge:
//       an_out <= onehot(idx)
//       seg_out <= glyph(idx)
//   - Each digit is therefore lit SCAN_DIV-1 cycles and dark for 1 cycle.
//   - First digit-0 light: the first edge after reset release.
//   - Outputs are registered. A load or err change is visible 1 edge later, if the digit is currently lit.
//   - Glyphs, positive logic, a=bit0:
//       0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//       'E'=79   '-'=40   blank=00
//   - Final output inverted when ACTIVE_LOW_SEG=1.
//   - Glyph priority:
//       err=1 -> 'E' (all digits)
//       else digit value 10..15 -> '-'
//       else BCD glyph (subject to SEG7_LZB_EN)
//   - Width rules:
//       idx is $clog2(NUM_DIGITS) bits, min 1
//       prescaler is $clog2(SCAN_DIV) bits
//       no other arithmetic
//   - NUM_DIGITS=1: idx stays 0; the guard cycle still occurs every SCAN_DIV cycles.
//   - load and the terminal count in the same cycle: both take effect. The new digit shows after the guard cycle.
//   - Reset mid-scan: outputs go dark immediately (async). The scan restarts at digit 0.
// CONFIGURATION
//   SEG7_LZB_EN defined: leading-zero blanking.
//     - Digit k>0 with value 0 shows blank when every digit j>k is also 0.
//     - Digit 0 is never blanked.
//     - err and '-' take priority over blanking.
//     - Non-BCD digits (10..15) count as non-zero.
//   SEG7_LZB_EN undefined: zero digits always show '0'. No blanking logic is synthesised.
// STRUCTURE
//   - Package seg7_pkg:
//       localparams GLYPH_0..GLYPH_9, GLYPH_E, GLYPH_DASH, GLYPH_BLANK (7-bit, positive logic)
//       function bcd_to_glyph(4-bit) -> 7-bit
//   - Sub-module seg7_glyph_rom: combinational {digit, err, blank} -> 7-bit positive-logic glyph.
//   - Scan counter, hold reg, LZB mask and polarity inversion live in the top module.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=4, both polarities active-low unless stated)
//   1. Reset released.
//        -> first edge: an_out=1110, seg_out=~3F=40.
//        -> period 16 cycles; each digit lit 3 cycles.
//        -> an_out=1111 / seg_out=7F on cycles 4, 8, 12, 16.
//   2. load with bcd_in=16'h1234.
//        -> scan shows 4(~66), 3(~4F), 2(~5B), 1(~06) on an 1110, 1101, 1011, 0111.
//   3. err=1 held for a full scan.
//        -> every lit slot has seg_out=~79=06.
//        -> err=0: the next lit slot reverts to the BCD glyph.
//   4. bcd_in=16'h00A5 loaded.
//        -> digit 1 shows '-' (~40=3F).
//        -> with SEG7_LZB_EN, digits 2 and 3 show blank (7F).
//        -> without SEG7_LZB_EN, digits 2 and 3 show '0' (40).
//   5. rst_n asserted mid-slot on digit 2.
//        -> outputs go 7F/1111 the same cycle.
//        -> after release, the scan restarts at digit 0.
//        -> the hold register reads 0.
//   6. ACTIVE_LOW_SEG=0, ACTIVE_LOW_AN=0, NUM_DIGITS=1, load 4'h7.
//        -> an_out=1, seg_out=07 for 3 cycles, then an_out=0 for 1 cycle, repeating.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants and BCD-to-segment helper for the seg7 scan driver.
// Glyphs are positive logic: bit0 = segment a .. bit6 = segment g.
package seg7_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;

   localparam logic [SEG_W-1:0] GLYPH_0     = 7'h3F;
   localparam logic [SEG_W-1:0] GLYPH_1     = 7'h06;
   localparam logic [SEG_W-1:0] GLYPH_2     = 7'h5B;
   localparam logic [SEG_W-1:0] GLYPH_3     = 7'h4F;
   localparam logic [SEG_W-1:0] GLYPH_4     = 7'h66;
   localparam logic [SEG_W-1:0] GLYPH_5     = 7'h6D;
   localparam logic [SEG_W-1:0] GLYPH_6     = 7'h7D;
   localparam logic [SEG_W-1:0] GLYPH_7     = 7'h07;
   localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
   localparam logic [SEG_W-1:0] GLYPH_9     = 7'h6F;
   localparam logic [SEG_W-1:0] GLYPH_E     = 7'h79;
   localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'h40;
   localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h00;

   // Non-BCD codes (10..15) render as a dash.
   function automatic logic [SEG_W-1:0] bcd_to_glyph(input logic [DIGIT_W-1:0] d);
      logic [SEG_W-1:0] g;
      case (d)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = GLYPH_DASH;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph lookup: error glyph, then dash for non-BCD, then blank, then BCD glyph.
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               err,
   input  logic               blank,
   output logic [SEG_W-1:0]   glyph_c
);

   always_comb begin
      glyph_c = GLYPH_BLANK;
      if (err) begin
         glyph_c = GLYPH_E;
      end else if (digit > 4'd9) begin
         glyph_c = GLYPH_DASH;
      end else if (blank) begin
         glyph_c = GLYPH_BLANK;
      end else begin
         glyph_c = bcd_to_glyph(digit);
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS x 7-segment driver with a one-cycle dark guard slot per digit.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned ACTIVE_LOW_SEG = 1,
   parameter int unsigned ACTIVE_LOW_AN  = 1
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
   input  logic                          load,
   input  logic                          err,
   output logic [SEG_W-1:0]              seg_out,
   output logic [NUM_DIGITS-1:0]         an_out
);

   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
   localparam int unsigned HOLD_W = DIGIT_W * NUM_DIGITS;

   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SEG_W-1:0]      SEG_OFF  = (ACTIVE_LOW_SEG != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW_AN != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [HOLD_W-1:0]     hold;
   logic [PRE_W-1:0]      presc;
   logic [IDX_W-1:0]      idx;

   logic                  term_c;
   logic [DIGIT_W-1:0]    cur_digit_c;
   logic                  cur_blank_c;
   logic [NUM_DIGITS-1:0] blank_vec_c;
   logic [NUM_DIGITS-1:0] onehot_c;
   logic [SEG_W-1:0]      glyph_c;
   logic [SEG_W-1:0]      seg_lit_c;
   logic [NUM_DIGITS-1:0] an_lit_c;

   // Digit hold register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
      end else if (load) begin
         hold <= bcd_in;
      end
   end

   assign term_c = (presc == PRE_LAST);

   // Prescaler, digit index and registered display outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         idx     <= '0;
         seg_out <= SEG_OFF;
         an_out  <= AN_OFF;
      end else if (term_c) begin
         presc   <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         seg_out <= SEG_OFF;
         an_out  <= AN_OFF;
      end else begin
         presc   <= presc + PRE_W'(1);
         seg_out <= seg_lit_c;
         an_out  <= an_lit_c;
      end
   end

`ifdef SEG7_LZB_EN
   // Digit k>0 blanks while it and every digit above it are zero; digit 0 never blanks.
   always_comb begin
      logic zero_run;
      zero_run    = 1'b1;
      blank_vec_c = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_run       = zero_run & (hold[k*DIGIT_W +: DIGIT_W] == 4'd0);
         blank_vec_c[k] = zero_run;
      end
   end
`else
   assign blank_vec_c = '0;
`endif

   // Select the scanned digit and its enable without indexing by idx directly
   always_comb begin
      cur_digit_c = '0;
      cur_blank_c = 1'b0;
      onehot_c    = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_digit_c = hold[k*DIGIT_W +: DIGIT_W];
            cur_blank_c = blank_vec_c[k];
            onehot_c[k] = 1'b1;
         end
      end
   end

   seg7_glyph_rom u_rom (
      .digit   (cur_digit_c),
      .err     (err),
      .blank   (cur_blank_c),
      .glyph_c (glyph_c)
   );

   assign seg_lit_c = (ACTIVE_LOW_SEG != 0) ? ~glyph_c : glyph_c;
   assign an_lit_c  = (ACTIVE_LOW_AN != 0) ? ~onehot_c : onehot_c;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit active-low instance and a 1-digit active-high instance.
module tb_seg7_scan_driver;

`ifdef SEG7_LZB_EN
   localparam logic [6:0] ZS = 7'h7F;
`else
   localparam logic [6:0] ZS = 7'h40;
`endif

   logic        clk;
   logic        rst_n;
   logic [15:0] bcd_in;
   logic        load;
   logic        err;
   logic [6:0]  seg_out;
   logic [3:0]  an_out;

   logic        rst1_n;
   logic [3:0]  bcd1;
   logic        load1;
   logic        err1;
   logic [6:0]  seg1;
   logic [0:0]  an1;

   int n_tests;
   int n_fail;

   seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) u0 (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load), .err(err),
      .seg_out(seg_out), .an_out(an_out)
   );

   seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(4), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0)) u1 (
      .clk(clk), .rst_n(rst1_n), .bcd_in(bcd1), .load(load1), .err(err1),
      .seg_out(seg1), .an_out(an1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] an_o, input logic [3:0] an_e,
                      input logic [6:0] seg_o, input logic [6:0] seg_e);
      n_tests++;
      assert (an_o === an_e) else begin
         n_fail++;
         $error("FAIL %s an_out=%h expected %h", tag, an_o, an_e);
      end
      n_tests++;
      assert (seg_o === seg_e) else begin
         n_fail++;
         $error("FAIL %s seg_out=%h expected %h", tag, seg_o, seg_e);
      end
   endtask

   initial begin
      logic [3:0] an_e;
      logic [6:0] seg_e;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bcd_in  = 16'h0000;
      load    = 1'b0;
      err     = 1'b0;
      rst1_n  = 1'b0;
      bcd1    = 4'h0;
      load1   = 1'b0;
      err1    = 1'b0;

      step(2);
      chk("reset4", an_out, 4'hF, seg_out, 7'h7F);
      chk("reset1", {3'b0, an1}, 4'h0, seg1, 7'h00);

      // 1: scan pattern after reset release, hold = 0
      rst_n = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         step(1);
         case ((c - 1) / 4)
            0:       an_e = 4'hE;
            1:       an_e = 4'hD;
            2:       an_e = 4'hB;
            default: an_e = 4'h7;
         endcase
         if (c % 4 == 0) begin
            an_e  = 4'hF;
            seg_e = 7'h7F;
         end else begin
            seg_e = (c <= 3) ? 7'h40 : ZS;
         end
         chk($sformatf("scan0_c%0d", c), an_out, an_e, seg_out, seg_e);
      end

      // 2: load 1234 at cycle 16, visible from cycle 18
      bcd_in = 16'h1234;
      load   = 1'b1;
      step(1);
      load = 1'b0;
      chk("ld_c17_old", an_out, 4'hE, seg_out, 7'h40);
      step(1);
      chk("d0_4", an_out, 4'hE, seg_out, 7'h19);
      step(4);
      chk("d1_3", an_out, 4'hD, seg_out, 7'h30);
      step(4);
      chk("d2_2", an_out, 4'hB, seg_out, 7'h24);
      step(4);
      chk("d3_1", an_out, 4'h7, seg_out, 7'h79);
      step(2);
      chk("guard_c32", an_out, 4'hF, seg_out, 7'h7F);

      // 3: err held for a full scan, then released mid-slot
      err = 1'b1;
      step(1);
      chk("err_d0", an_out, 4'hE, seg_out, 7'h06);
      step(4);
      chk("err_d1", an_out, 4'hD, seg_out, 7'h06);
      step(4);
      chk("err_d2", an_out, 4'hB, seg_out, 7'h06);
      step(4);
      chk("err_d3", an_out, 4'h7, seg_out, 7'h06);
      err = 1'b0;
      step(1);
      chk("err_off_d3", an_out, 4'h7, seg_out, 7'h79);

      // 4: dash and leading zeros with 00A5
      bcd_in = 16'h00A5;
      load   = 1'b1;
      step(1);
      load = 1'b0;
      step(2);
      chk("a5_d0", an_out, 4'hE, seg_out, 7'h12);
      step(4);
      chk("a5_d1_dash", an_out, 4'hD, seg_out, 7'h3F);
      step(4);
      chk("a5_d2_zero", an_out, 4'hB, seg_out, ZS);
      step(4);
      chk("a5_d3_zero", an_out, 4'h7, seg_out, ZS);

      // 5: async reset mid-slot on digit 2
      step(13);
      chk("pre_rst_d2", an_out, 4'hB, seg_out, ZS);
      rst_n = 1'b0;
      #1;
      chk("rst_async", an_out, 4'hF, seg_out, 7'h7F);
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("rst_restart_d0", an_out, 4'hE, seg_out, 7'h40);
      step(4);
      chk("rst_hold_d1", an_out, 4'hD, seg_out, ZS);

      // 6: single active-high digit
      rst1_n = 1'b1;
      bcd1   = 4'h7;
      load1  = 1'b1;
      step(1);
      load1 = 1'b0;
      chk("one_c1", {3'b0, an1}, 4'h1, seg1, 7'h3F);
      step(1);
      chk("one_c2", {3'b0, an1}, 4'h1, seg1, 7'h07);
      step(1);
      chk("one_c3", {3'b0, an1}, 4'h1, seg1, 7'h07);
      step(1);
      chk("one_guard", {3'b0, an1}, 4'h0, seg1, 7'h00);
      for (int c = 5; c <= 8; c++) begin
         step(1);
         if (c == 8) chk("one_guard2", {3'b0, an1}, 4'h0, seg1, 7'h00);
         else        chk($sformatf("one_c%0d", c), {3'b0, an1}, 4'h1, seg1, 7'h07);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
